adc_cfg_sequencer: RTL and testbench

ADC_CFG_SEQUENCER -- requirements
Module: adc_cfg_sequencer

---
 rtl/adc_cfg_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_cfg_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cfg_sequencer.sv
// ADC configuration sequencer: RESET pulse, post-reset wait, then serial write of a
// register table (or a single host word) over SEN/SCLK/SDATA, MSB first.
// Latency: start -> RESET high on the next edge; every pin output is registered.
// Backpressure: wr_req is held by the requester until the one-cycle wr_ack; start is
// ignored while busy.
// Ports: clk_50 / reset_n (sync, active-low); start; tbl_idx -> tbl_word lookup;
// wr_req / wr_word / wr_ack host write; adc_reset, sclk, sen, sdata ADC pins;
// busy (not IDLE/DONE); done (init complete, sticky).
module adc_cfg_sequencer #(
  parameter int SCLK_DIV   = 5,
  parameter int RST_CYCLES = 10,
  parameter int RST_WAIT   = 100,
  parameter int GAP_CYCLES = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        start,
  output logic [3:0]  tbl_idx,
  input  logic [23:0] tbl_word,
  input  logic        wr_req,
  input  logic [23:0] wr_word,
  output logic        wr_ack,
  output logic        adc_reset,
  output logic        sclk,
  output logic        sen,
  output logic        sdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_PULSE, S_RST_HOLD, S_LOAD, S_SHIFT, S_GAP, S_DONE
  } state_t;

  // One shared counter serves RESET width, post-reset wait and gap timing.
  localparam int CNT_MAX_A = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int DW        = $clog2(SCLK_DIV + 1);

  localparam logic [CW-1:0] RST_LAST      = CW'(RST_CYCLES - 1);
  // The one-cycle LOAD is counted as part of the wait/gap, so the SEN-high time
  // seen on the pins equals the parameter exactly.
  localparam logic [CW-1:0] WAIT_LAST     = CW'(RST_WAIT - 2);
  localparam logic [CW-1:0] GAP_LOAD_LAST = CW'(GAP_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST      = CW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST      = DW'(SCLK_DIV - 1);
  localparam logic [3:0]    IDX_LAST      = 4'(NUM_WORDS - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [4:0]    r_bit, w_bit_nxt;
  logic [23:0]   r_shreg, w_shreg_nxt;
  logic          r_init, w_init_nxt;
  logic [3:0]    r_tbl_idx, w_idx_nxt;
  logic          r_wr_ack, w_wr_ack_nxt;
  logic          r_adc_reset, w_adc_reset_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_sen, w_sen_nxt;
  logic          r_sdata, w_sdata_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          w_more;
  logic [23:0]   w_load_word;

  // More table words remain only during an init sequence.
  assign w_more      = r_init && (r_tbl_idx < IDX_LAST);
  assign w_load_word = r_init ? tbl_word : wr_word;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_init      <= 1'b0;
      r_tbl_idx   <= '0;
      r_wr_ack    <= 1'b0;
      r_adc_reset <= 1'b0;
      r_sclk      <= 1'b1;
      r_sen       <= 1'b1;
      r_sdata     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_bit       <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_init      <= w_init_nxt;
      r_tbl_idx   <= w_idx_nxt;
      r_wr_ack    <= w_wr_ack_nxt;
      r_adc_reset <= w_adc_reset_nxt;
      r_sclk      <= w_sclk_nxt;
      r_sen       <= w_sen_nxt;
      r_sdata     <= w_sdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_div_nxt       = '0;
    w_bit_nxt       = r_bit;
    w_shreg_nxt     = r_shreg;
    w_init_nxt      = r_init;
    w_idx_nxt       = r_tbl_idx;
    w_wr_ack_nxt    = 1'b0;
    w_adc_reset_nxt = 1'b0;
    w_sclk_nxt      = r_sclk;
    w_sen_nxt       = r_sen;
    w_sdata_nxt     = r_sdata;
    w_done_nxt      = r_done;

    case (r_state)
      S_IDLE, S_DONE: begin
        // start has priority; a simultaneous wr_req stays pending.
        if (start) begin
          w_state_nxt     = S_RST_PULSE;
          w_adc_reset_nxt = 1'b1;
          w_init_nxt      = 1'b1;
          w_idx_nxt       = '0;
          w_done_nxt      = 1'b0;
        end else if (wr_req) begin
          w_state_nxt  = S_LOAD;
          w_wr_ack_nxt = 1'b1;
          w_init_nxt   = 1'b0;
        end
      end
      S_RST_PULSE: begin
        w_adc_reset_nxt = 1'b1;
        w_cnt_nxt       = r_cnt + 1'b1;
        if (r_cnt == RST_LAST) begin
          w_adc_reset_nxt = 1'b0;
          w_cnt_nxt       = '0;
          // A one-cycle wait is fully covered by LOAD itself.
          w_state_nxt     = (RST_WAIT == 1) ? S_LOAD : S_RST_HOLD;
        end
      end
      S_RST_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == WAIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_shreg_nxt = w_load_word;
        w_sdata_nxt = w_load_word[23];
        w_sen_nxt   = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_bit_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_div_nxt = r_div + 1'b1;
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else if (r_bit == 5'd23) begin
            w_sen_nxt   = 1'b1;
            w_sclk_nxt  = 1'b1;
            w_sdata_nxt = 1'b0;
            if (w_more && (GAP_CYCLES == 1)) begin
              w_idx_nxt   = r_tbl_idx + 4'd1;
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_GAP;
            end
          end else begin
            // Falling SCLK edge: present the next bit.
            w_sclk_nxt  = 1'b0;
            w_bit_nxt   = r_bit + 5'd1;
            w_shreg_nxt = {r_shreg[22:0], 1'b0};
            w_sdata_nxt = r_shreg[22];
          end
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_more) begin
          if (r_cnt == GAP_LOAD_LAST) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_tbl_idx + 4'd1;
            w_state_nxt = S_LOAD;
          end
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_init) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            // done is untouched by host writes, so it records where we came from.
            w_state_nxt = r_done ? S_DONE : S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
  end

  assign tbl_idx   = r_tbl_idx;
  assign wr_ack    = r_wr_ack;
  assign adc_reset = r_adc_reset;
  assign sclk      = r_sclk;
  assign sen       = r_sen;
  assign sdata     = r_sdata;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer (SCLK_DIV=2, RST_CYCLES=3, RST_WAIT=5,
// GAP_CYCLES=2, NUM_WORDS=3). A pin monitor decodes SEN/SCLK/SDATA into words
// and timestamps; each test task checks its own expectations.
`timescale 1ns/1ps
module tb_adc_cfg_sequencer;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  tbl_idx;
  logic [23:0] tbl_word;
  logic        wr_req = 1'b0;
  logic [23:0] wr_word = '0;
  logic        wr_ack, adc_reset, sclk, sen, sdata, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] exp_tbl [0:2];

  always #10 clk_50 = ~clk_50;

  adc_cfg_sequencer #(
    .SCLK_DIV(2), .RST_CYCLES(3), .RST_WAIT(5), .GAP_CYCLES(2), .NUM_WORDS(3)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .start(start),
    .tbl_idx(tbl_idx), .tbl_word(tbl_word),
    .wr_req(wr_req), .wr_word(wr_word), .wr_ack(wr_ack),
    .adc_reset(adc_reset), .sclk(sclk), .sen(sen), .sdata(sdata),
    .busy(busy), .done(done)
  );

  always_comb begin
    tbl_word = 24'h0;
    if (tbl_idx < 4'd3) tbl_word = exp_tbl[tbl_idx];
  end

  // Pin monitor
  int          cyc = 0;
  int          rst_rise = 0, rst_fall = 0;
  int          q_fall[$], q_rise[$], q_bits[$];
  logic [23:0] q_word[$];
  logic [23:0] cur_word = '0;
  int          cur_bits = 0;
  int          viol = 0;
  logic        p_rst = 1'b0, p_sen = 1'b1, p_sclk = 1'b1, p_sdata = 1'b0;

  always @(negedge clk_50) begin
    cyc++;
    if (adc_reset === 1'b1 && p_rst === 1'b0) rst_rise = cyc;
    if (adc_reset === 1'b0 && p_rst === 1'b1) rst_fall = cyc;
    if (sen === 1'b0 && p_sen === 1'b1) begin
      q_fall.push_back(cyc);
      cur_bits = 0;
      cur_word = '0;
    end
    if (sen === 1'b0 && p_sen === 1'b0) begin
      if (sclk === 1'b1 && p_sclk === 1'b0) begin
        cur_word = {cur_word[22:0], sdata};
        cur_bits++;
      end
      if (sdata !== p_sdata && !(p_sclk === 1'b1 && sclk === 1'b0)) viol++;
    end
    if (sen === 1'b1 && p_sen === 1'b0) begin
      q_rise.push_back(cyc);
      q_word.push_back(cur_word);
      q_bits.push_back(cur_bits);
    end
    p_rst = adc_reset; p_sen = sen; p_sclk = sclk; p_sdata = sdata;
  end

  task automatic clear_mon();
    q_fall.delete(); q_rise.delete(); q_bits.delete(); q_word.delete();
    viol = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk_50); start = 1'b1;
    @(negedge clk_50); start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_50);
    tests_run++; if (adc_reset !== 1'b0) begin tests_failed++; $display("FAIL rst_adc_reset got %b want 0", adc_reset); end
    tests_run++; if (sclk !== 1'b1) begin tests_failed++; $display("FAIL rst_sclk got %b want 1", sclk); end
    tests_run++; if (sen !== 1'b1) begin tests_failed++; $display("FAIL rst_sen got %b want 1", sen); end
    tests_run++; if (sdata !== 1'b0) begin tests_failed++; $display("FAIL rst_sdata got %b want 0", sdata); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got %b want 0", done); end
    tests_run++; if (wr_ack !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_ack got %b want 0", wr_ack); end
    tests_run++; if (tbl_idx !== 4'd0) begin tests_failed++; $display("FAIL rst_tbl_idx got %0d want 0", tbl_idx); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  // Full init; with poke=1 an extra start is pulsed mid-SHIFT and must be ignored.
  task automatic test_init(input bit poke);
    int n;
    clear_mon();
    pulse_start();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL init_done_clr got %b want 0", done); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL init_busy got %b want 1", busy); end
    if (poke) begin
      n = 0;
      while (sen !== 1'b0 && n < 100) begin @(negedge clk_50); n++; end
      repeat (30) @(negedge clk_50);
      start = 1'b1; @(negedge clk_50); start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk_50); n++; end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL init_timeout done=%b want 1", done); end
    repeat (3) @(negedge clk_50);
    tests_run++; if (rst_fall - rst_rise != 3) begin tests_failed++; $display("FAIL init_rst_width got %0d want 3", rst_fall - rst_rise); end
    tests_run++; if (q_word.size() != 3) begin tests_failed++; $display("FAIL init_word_count got %0d want 3", q_word.size()); end
    if (q_fall.size() > 0) begin
      tests_run++; if (q_fall[0] - rst_fall != 5) begin tests_failed++; $display("FAIL init_wait got %0d want 5", q_fall[0] - rst_fall); end
    end
    for (int i = 0; i < 3; i++) begin
      if (i < q_word.size()) begin
        tests_run++; if (q_word[i] !== exp_tbl[i]) begin tests_failed++; $display("FAIL init_word%0d got %h want %h", i, q_word[i], exp_tbl[i]); end
        tests_run++; if (q_bits[i] != 24) begin tests_failed++; $display("FAIL init_bits%0d got %0d want 24", i, q_bits[i]); end
        tests_run++; if (q_rise[i] - q_fall[i] != 96) begin tests_failed++; $display("FAIL init_len%0d got %0d want 96", i, q_rise[i] - q_fall[i]); end
      end
      if (i < 2 && i + 1 < q_fall.size()) begin
        tests_run++; if (q_fall[i+1] - q_rise[i] != 2) begin tests_failed++; $display("FAIL init_gap%0d got %0d want 2", i, q_fall[i+1] - q_rise[i]); end
      end
    end
    tests_run++; if (viol != 0) begin tests_failed++; $display("FAIL init_sdata_stable got %0d changes want 0", viol); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL init_busy_end got %b want 0", busy); end
  endtask

  task automatic test_host_write();
    int n, acks;
    bit done_drop;
    clear_mon();
    done_drop = 1'b0;
    @(negedge clk_50); wr_word = 24'h02E000; wr_req = 1'b1;
    n = 0;
    while (wr_ack !== 1'b1 && n < 50) begin @(negedge clk_50); n++; end
    tests_run++; if (wr_ack !== 1'b1) begin tests_failed++; $display("FAIL host_ack_timeout got %b want 1", wr_ack); end
    wr_req = 1'b0;
    acks = 1;
    n = 0;
    do begin
      @(negedge clk_50); n++;
      if (wr_ack === 1'b1) acks++;
      if (done !== 1'b1) done_drop = 1'b1;
    end while (busy !== 1'b0 && n < 500);
    repeat (2) @(negedge clk_50);
    tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL host_ack_len got %0d want 1", acks); end
    tests_run++; if (q_word.size() != 1) begin tests_failed++; $display("FAIL host_word_count got %0d want 1", q_word.size()); end
    if (q_word.size() > 0) begin
      tests_run++; if (q_word[0] !== 24'h02E000) begin tests_failed++; $display("FAIL host_word got %h want 02e000", q_word[0]); end
      tests_run++; if (q_rise[0] - q_fall[0] != 96) begin tests_failed++; $display("FAIL host_len got %0d want 96", q_rise[0] - q_fall[0]); end
    end
    tests_run++; if (done_drop || done !== 1'b1) begin tests_failed++; $display("FAIL host_done_sticky drop=%0d done=%b want 0/1", done_drop, done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL host_busy_end got %b want 0", busy); end
  endtask

  task automatic test_collision();
    int n, k;
    bit early_ack;
    reset_n = 1'b0;
    repeat (2) @(negedge clk_50);
    reset_n = 1'b1;
    clear_mon();
    early_ack = 1'b0;
    @(negedge clk_50); start = 1'b1; wr_req = 1'b1; wr_word = 24'hC30F0F;
    @(negedge clk_50); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      if (wr_ack === 1'b1) early_ack = 1'b1;
      @(negedge clk_50); n++;
    end
    tests_run++; if (early_ack) begin tests_failed++; $display("FAIL coll_early_ack got 1 want 0"); end
    k = 0;
    while (wr_ack !== 1'b1 && k < 20) begin @(negedge clk_50); k++; end
    tests_run++; if (k != 1) begin tests_failed++; $display("FAIL coll_ack_delay got %0d want 1", k); end
    wr_req = 1'b0;
    n = 0;
    do begin @(negedge clk_50); n++; end while (busy !== 1'b0 && n < 500);
    repeat (2) @(negedge clk_50);
    tests_run++; if (q_word.size() != 4) begin tests_failed++; $display("FAIL coll_word_count got %0d want 4", q_word.size()); end
    if (q_word.size() == 4) begin
      tests_run++; if (q_word[0] !== exp_tbl[0]) begin tests_failed++; $display("FAIL coll_first got %h want %h", q_word[0], exp_tbl[0]); end
      tests_run++; if (q_word[3] !== 24'hC30F0F) begin tests_failed++; $display("FAIL coll_host got %h want c30f0f", q_word[3]); end
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL coll_done got %b want 1", done); end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    clear_mon();
    pulse_start();
    n = 0;
    while (!(tbl_idx == 4'd1 && sen === 1'b0 && cur_bits == 10) && n < 2000) begin @(negedge clk_50); n++; end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_reach busy=%b idx=%0d want 1/1", busy, tbl_idx); end
    reset_n = 1'b0;
    @(negedge clk_50);
    tests_run++; if (sen !== 1'b1) begin tests_failed++; $display("FAIL mid_sen got %b want 1", sen); end
    tests_run++; if (sclk !== 1'b1) begin tests_failed++; $display("FAIL mid_sclk got %b want 1", sclk); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_done got %b want 0", done); end
    tests_run++; if (tbl_idx !== 4'd0) begin tests_failed++; $display("FAIL mid_idx got %0d want 0", tbl_idx); end
    reset_n = 1'b1;
    @(negedge clk_50);
    clear_mon();
    pulse_start();
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk_50); n++; end
    repeat (3) @(negedge clk_50);
    tests_run++; if (q_word.size() != 3) begin tests_failed++; $display("FAIL restart_count got %0d want 3", q_word.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_word.size()) begin
        tests_run++; if (q_word[i] !== exp_tbl[i]) begin tests_failed++; $display("FAIL restart_word%0d got %h want %h", i, q_word[i], exp_tbl[i]); end
      end
    end
  endtask

  initial begin
    exp_tbl[0] = 24'h990008;
    exp_tbl[1] = 24'hA55A3C;
    exp_tbl[2] = 24'h018001;
    test_reset();
    test_init(1'b0);
    test_host_write();
    test_init(1'b1);
    test_collision();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
